// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bundle: instruction memory handshake plus the decode/execute side.
// master: the fetch unit (drives request, address, instr, pc, link_pc, fault).
// slave : memory + decode/execute (drives ack, rdata, retire and next-PC controls).
interface instr_fetch_unit_if;
    // instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // decode / execute side
    logic [31:0] instr;
    logic        instr_valid;
    logic [31:0] pc;
    logic [31:0] link_pc;
    logic        retire;
    logic        branch;
    logic        zero;
    logic        jump;
    logic        jsp;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] reg_target;
    logic        fault;

    modport master (
        output imem_req, imem_addr, instr, instr_valid, pc, link_pc, fault,
        input  imem_ack, imem_rdata, retire, branch, zero, jump, jsp,
               imm16, target26, reg_target
    );

    modport slave (
        input  imem_req, imem_addr, instr, instr_valid, pc, link_pc, fault,
        output imem_ack, imem_rdata, retire, branch, zero, jump, jsp,
               imm16, target26, reg_target
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Purpose: MIPS-lite program counter, instruction fetch and next-PC selection.
// Latency: instr_valid the edge after imem_ack; pc updates the edge after retire (2-cycle minimum period).
// Backpressure: request/address held until imem_ack; instr held until retire; HALT on misaligned jsp.
//
// Ports: clk, rst_n (async active-low); bus (instr_fetch_unit_if.master) carries the
// imem req/addr/ack/rdata handshake, instr/instr_valid/pc/link_pc to decode, the
// retire + branch/zero/jump/jsp/imm16/target26/reg_target controls back, and fault.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        ISSUE = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic        valid_q;
    logic        fault_q;

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic [31:0] next_pc;
    logic        jsp_misaligned;

    // Next-PC select; fixed priority jsp > jump > taken branch > fall-through.
    always_comb begin
        pc4    = pc_q + 32'd4;
        br_off = {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
        if (bus.jsp) begin
            next_pc = bus.reg_target;
        end else if (bus.jump) begin
            next_pc = {pc4[31:28], bus.target26, 2'b00};
        end else if (bus.branch && bus.zero) begin
            next_pc = pc4 + br_off;
        end else begin
            next_pc = pc4;
        end
    end

    // Only a jsp can produce a misaligned target; jump/branch are aligned by construction.
    assign jsp_misaligned = bus.jsp && (bus.reg_target[1:0] != 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            pc_q    <= RESET_PC;
            instr_q <= 32'd0;
            valid_q <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (bus.imem_ack) begin
                        instr_q <= bus.imem_rdata;
                        valid_q <= 1'b1;
                        state   <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (bus.retire) begin
                        valid_q <= 1'b0;
                        if (jsp_misaligned) begin
                            // pc stays at the faulting instruction for post-mortem.
                            fault_q <= 1'b1;
                            state   <= HALT;
                        end else begin
                            pc_q  <= next_pc;
                            state <= FETCH;
                        end
                    end
                end
                HALT: begin
                    state <= HALT;
                end
                default: begin
                    state <= HALT;
                end
            endcase
        end
    end

    // Request decodes straight from the state register so it can rise in the very
    // first cycle after reset release; gating with rst_n drops it the instant
    // reset asserts, abandoning any in-flight access.
    assign bus.imem_req    = rst_n && (state == FETCH);
    assign bus.imem_addr   = pc_q;
    assign bus.instr       = instr_q;
    assign bus.instr_valid = valid_q;
    assign bus.pc          = pc_q;
    assign bus.link_pc     = pc4;
    assign bus.fault       = fault_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    instr_fetch_unit_if ifc();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifc)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory contents: an arbitrary but address-dependent word.
    function automatic logic [31:0] instr_at(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    // Next PC straight from the architectural rules, using signed arithmetic.
    function automatic logic [31:0] model_next(input logic [31:0] cur, input logic js,
                                               input logic jp, input logic br, input logic z,
                                               input logic [15:0] imm, input logic [25:0] t26,
                                               input logic [31:0] rt);
        logic [31:0] ret;
        logic signed [31:0] off;
        ret = cur + 32'd4;
        if (js) return rt;
        if (jp) return (ret & 32'hF000_0000) | ({6'd0, t26} * 4);
        if (br && z) begin
            off = 32'($signed(imm));
            off = off * 4;
            return ret + off;
        end
        return ret;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Tracks the architectural view: current pc, held instruction, whether one
    // is pending retire, and whether the core has faulted.
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_instr = 32'h0;
    logic        m_valid = 1'b0;
    logic        m_fault = 1'b0;
    logic [31:0] tgt;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc = 32'h0; m_instr = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        end else if (!m_fault) begin
            if (!m_valid) begin
                if (ifc.imem_ack) begin
                    m_instr = instr_at(m_pc);
                    m_valid = 1'b1;
                end
            end else if (ifc.retire) begin
                tgt = model_next(m_pc, ifc.jsp, ifc.jump, ifc.branch, ifc.zero,
                                 ifc.imm16, ifc.target26, ifc.reg_target);
                m_valid = 1'b0;
                if (ifc.jsp && (tgt % 4 != 0)) m_fault = 1'b1;
                else m_pc = tgt;
            end
        end
    end

    // Single compare process, every cycle, away from the active edge.
    always @(negedge clk) begin
        chk("imem_req",    {31'd0, ifc.imem_req},    {31'd0, rst_n && !m_valid && !m_fault});
        chk("imem_addr",   ifc.imem_addr,            m_pc);
        chk("pc",          ifc.pc,                   m_pc);
        chk("instr_valid", {31'd0, ifc.instr_valid}, {31'd0, m_valid});
        chk("instr",       ifc.instr,                m_instr);
        chk("fault",       {31'd0, ifc.fault},       {31'd0, m_fault});
        if (m_valid) chk("link_pc", ifc.link_pc, m_pc + 32'd4);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input int waits);
        logic [31:0] a0;
        a0 = ifc.imem_addr;
        for (int i = 0; i < waits; i++) begin
            ifc.imem_ack = 1'b0;
            step();
            chk("req_held",  {31'd0, ifc.imem_req}, 32'd1);
            chk("addr_held", ifc.imem_addr, a0);
        end
        ifc.imem_ack   = 1'b1;
        ifc.imem_rdata = instr_at(ifc.imem_addr);
        step();
        ifc.imem_ack   = 1'b0;
        ifc.imem_rdata = 32'h0;
    endtask

    task automatic issue(input int dly, input logic br, input logic z, input logic jp,
                         input logic js, input logic [15:0] imm, input logic [25:0] t26,
                         input logic [31:0] rt);
        ifc.branch = br; ifc.zero = z; ifc.jump = jp; ifc.jsp = js;
        ifc.imm16 = imm; ifc.target26 = t26; ifc.reg_target = rt;
        ifc.retire = 1'b0;
        for (int i = 0; i < dly; i++) step();
        ifc.retire = 1'b1;
        step();
        ifc.retire = 1'b0;
        ifc.branch = 1'b0; ifc.zero = 1'b0; ifc.jump = 1'b0; ifc.jsp = 1'b0;
        ifc.imm16 = 16'h0; ifc.target26 = 26'h0; ifc.reg_target = 32'h0;
    endtask

    task automatic plain();
        issue(0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0, 32'h0);
    endtask

    task automatic go_to(input logic [31:0] a);
        fetch(0);
        issue(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, a);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int last_vld;
        ifc.imem_ack = 1'b0; ifc.imem_rdata = 32'h0; ifc.retire = 1'b0;
        ifc.branch = 1'b0; ifc.zero = 1'b0; ifc.jump = 1'b0; ifc.jsp = 1'b0;
        ifc.imm16 = 16'h0; ifc.target26 = 26'h0; ifc.reg_target = 32'h0;
        #1 rst_n = 1'b0;
        step(); step();
        chk("rst_req",   {31'd0, ifc.imem_req},    32'd0);
        chk("rst_pc",    ifc.pc,                   32'h0);
        chk("rst_instr", ifc.instr,                32'h0);
        chk("rst_vld",   {31'd0, ifc.instr_valid}, 32'd0);
        rst_n = 1'b1;
        #1 chk("req_after_rst", {31'd0, ifc.imem_req}, 32'd1);

        // Sequential fetch: 0,4,8,C with one instruction every 2 cycles.
        last_vld = 0;
        for (int i = 0; i < 4; i++) begin
            chk("seq_addr", ifc.imem_addr, 32'(i * 4));
            fetch(0);
            chk("seq_vld", {31'd0, ifc.instr_valid}, 32'd1);
            if (i > 0) chk("seq_period", 32'(cyc - last_vld), 32'd2);
            last_vld = cyc;
            plain();
        end
        chk("seq_pc_10", ifc.pc, 32'h10);

        // beq taken at 0x10 with offset -4 words -> 0x04.
        fetch(0);
        issue(0, 1'b1, 1'b1, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        chk("beq_taken", ifc.pc, 32'h4);
        for (int i = 0; i < 3; i++) begin fetch(0); plain(); end
        chk("back_to_10", ifc.pc, 32'h10);
        fetch(0);
        issue(0, 1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFC, 26'h0, 32'h0);
        chk("beq_not_taken", ifc.pc, 32'h14);

        // jal from 0x1000_0008.
        go_to(32'h1000_0008);
        fetch(0);
        chk("jal_link", ifc.link_pc, 32'h1000_000C);
        issue(0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h0000040, 32'h0);
        chk("jal_target", ifc.pc, 32'h1000_0100);

        // Three wait states, then a stray ack and ignored controls during ISSUE.
        fetch(3);
        ifc.imem_ack = 1'b1; ifc.imem_rdata = 32'hDEAD_BEEF;
        step();
        ifc.imem_ack = 1'b0;
        chk("stray_ack", ifc.instr, instr_at(32'h1000_0100));
        issue(2, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 26'h3FF_FFFF, 32'h0);
        chk("after_wait", ifc.pc, 32'hF000_0104 & 32'h1FFF_FFFF | 32'h0FFF_FFFC);

        // Wrap-around.
        go_to(32'hFFFF_FFFC);
        fetch(0);
        chk("wrap_link", ifc.link_pc, 32'h0);
        plain();
        chk("wrap_pc", ifc.pc, 32'h0);

        // Priority jsp > jump > branch.
        fetch(0);
        issue(0, 1'b1, 1'b1, 1'b1, 1'b1, 16'h0010, 26'h0000123, 32'h200);
        chk("prio_jsp", ifc.pc, 32'h200);

        // Reset during a FETCH wait.
        ifc.imem_ack = 1'b0;
        step(); step();
        rst_n = 1'b0;
        #1;
        chk("rstf_vld", {31'd0, ifc.instr_valid}, 32'd0);
        chk("rstf_req", {31'd0, ifc.imem_req},    32'd0);
        chk("rstf_pc",  ifc.pc,                   32'h0);
        step(); step();
        rst_n = 1'b1;
        fetch(0);
        plain();
        chk("restart_pc", ifc.pc, 32'h4);

        // Reset during ISSUE.
        fetch(0);
        rst_n = 1'b0;
        #1;
        chk("rsti_vld", {31'd0, ifc.instr_valid}, 32'd0);
        chk("rsti_req", {31'd0, ifc.imem_req},    32'd0);
        chk("rsti_pc",  ifc.pc,                   32'h0);
        step();
        rst_n = 1'b1;
        #1;
        chk("rsti_addr", ifc.imem_addr, 32'h0);
        chk("rsti_req1", {31'd0, ifc.imem_req}, 32'd1);

        // Misaligned jsp -> HALT, everything frozen afterwards.
        step();
        fetch(0);
        issue(0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 26'h0, 32'h202);
        chk("fault_set",  {31'd0, ifc.fault},       32'd1);
        chk("fault_pc",   ifc.pc,                   32'h0);
        chk("fault_vld",  {31'd0, ifc.instr_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            ifc.retire = 1'b1; ifc.imem_ack = 1'b1; ifc.imem_rdata = 32'hCAFE_F00D;
            ifc.jsp = 1'b1; ifc.reg_target = 32'h400;
            step();
            chk("halt_req", {31'd0, ifc.imem_req}, 32'd0);
            chk("halt_pc",  ifc.pc,                32'h0);
        end
        ifc.retire = 1'b0; ifc.imem_ack = 1'b0; ifc.jsp = 1'b0;
        step(); step();
        chk("fault_sticky", {31'd0, ifc.fault}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch and next-PC stage of the MIPS-lite core. It sits directly upstream of the opcode control decoder. It holds the program counter, fetches one 32-bit instruction per step from an instruction memory over a req/ack handshake, and presents it to decode until the instruction retires. It then computes the next PC from the branch/jump/jal/jsp controls returned by decode and execute.

## Interface

Parameters:

- RESET_PC, 32'h0000_0000, PC loaded on reset (must be word aligned).

Ports:

- clk  input  1  single clock, all state updates on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; always equal to pc.
- imem_ack  input  1  memory returns imem_rdata this cycle.
- imem_rdata  input  32  fetched instruction word.
- instr  output  32  registered instruction; bits [31:26] feed the control decoder.
- instr_valid  output  1  instr is valid and awaiting retire.
- pc  output  32  address of the current instruction.
- link_pc  output  32  pc+4, the return address written by jal.
- retire  input  1  current instruction completes; controls below are sampled this cycle.
- branch  input  1  beq decoded.
- zero  input  1  ALU zero flag.
- jump  input  1  jal decoded (pseudo-direct jump).
- jsp  input  1  jsp decoded (register-indirect jump).
- imm16  input  16  branch offset (instr[15:0]).
- target26  input  26  jump index (instr[25:0]).
- reg_target  input  32  jsp destination address.
- fault  output  1  sticky misaligned-target fault.

## Operation

- The state machine has three states: FETCH, ISSUE, HALT. Reset state is FETCH.
- **FETCH:** imem_req=1 and imem_addr=pc.
  - On imem_ack=1: capture imem_rdata into instr, set instr_valid, and go to ISSUE.
  - Otherwise remain in FETCH with request and address held stable.
- **ISSUE:** imem_req=0 and instr_valid=1.
  - On retire=1: load pc with next_pc, clear instr_valid, and go to FETCH.
  - Exception: a jsp to a misaligned target goes to HALT instead (see below).
- **HALT:** fault=1 and imem_req=0, instr_valid=0, pc frozen. Only rst_n exits HALT.
- Next-PC computation, with pc4 = pc+4:
  - If jsp: reg_target.
  - Else if jump: {pc4[31:28], target26, 2'b00}.
  - Else if branch & zero: pc4 + ({{14{imm16[15]}}, imm16, 2'b00}).
  - Else: pc4.
  - Priority is fixed as jsp > jump > branch when several are asserted.
- All additions are modulo 2^32, and wrap silently: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
- A jsp whose reg_target[1:0] != 0 sets fault, goes to HALT, and leaves pc unchanged. Jump and branch targets are aligned by construction.
- link_pc = pc4 combinationally, valid while instr_valid=1.
- Inputs are ignored outside their own state:
  - imem_ack outside FETCH is ignored.
  - retire outside ISSUE is ignored.
  - Control inputs are ignored unless retire=1 in ISSUE.
- Reset values: pc=RESET_PC, instr=0, instr_valid=0, imem_req=0 while rst_n=0, fault=0.
  - imem_req rises in the first cycle after rst_n deasserts.

## Timing

- Reset assertion clears all registers and drops imem_req immediately, without waiting for a clock edge.
- Assertion mid-fetch abandons the access; the memory must tolerate a dropped request.
- Zero-wait memory: imem_ack may be high in the same cycle imem_req rises. instr_valid is then high after that edge.
- Minimum instruction period is 2 cycles (FETCH, ISSUE). Each memory wait cycle adds one cycle; each cycle of retire delay adds one cycle.
- retire may be asserted in the first ISSUE cycle. The next request then goes out on the following cycle.
- pc, imem_addr and instr change only on the edges described above. They are glitch-free registered outputs, except link_pc, which is combinational from pc.
- fault asserts on the edge following the offending retire and stays high until reset.

## Test plan

- **Reset and sequential fetch.** Stimulus: RESET_PC=0, memory ack in the same cycle, retire every ISSUE, no controls. Required: imem_addr sequence 0,4,8,C; a new instr_valid every 2 cycles; fault=0.
- **Taken and not-taken beq.** Stimulus: at pc=0x10, branch=1 with imm16=16'hFFFC.
  - With zero=1: next pc = 0x14-0x10 = 0x04.
  - With zero=0: next pc = 0x14.
- **jal.** Stimulus: pc=0x1000_0008, jump=1, target26=26'h0000040. Required: link_pc=0x1000_000C during ISSUE; next pc = 0x1000_0100.
- **jsp priority and fault.** Stimulus 1: jsp=1, jump=1, branch=1, zero=1, reg_target=0x200. Required: next pc = 0x200.
  - Stimulus 2: retire a jsp with reg_target=0x202. Required: fault=1, HALT, imem_req stays 0, pc unchanged, and retire ignored afterwards.
- **Memory wait states and wrap.** Stimulus: ack delayed 3 cycles. Required: imem_req and imem_addr held for 4 cycles, and a stray ack during ISSUE is ignored.
  - Stimulus: pc=0xFFFF_FFFC, plain retire. Required: next pc = 0x0000_0000.
- **Reset mid-operation.** Stimulus: drop rst_n during a FETCH wait and during ISSUE. Required: instr_valid=0, imem_req=0, pc=RESET_PC immediately, and fetch restarts at RESET_PC after release.
